// File: rtl/spi_master_ctrl_if.sv
// Command/response/configuration bundle between the register front end
// (master side) and the SPI engine (slave side).
interface spi_master_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 3,
   parameter int DIV_W  = 8
);
   logic              cfg_en;
   logic              cfg_cpol;
   logic              cfg_cpha;
   logic [DIV_W-1:0]  cfg_div;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_data;
   logic [NUM_SS-1:0] cmd_ss;
   logic              cmd_last;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              fault;
   logic              fault_clr;

   modport master (
      output cfg_en, cfg_cpol, cfg_cpha, cfg_div,
      output cmd_valid, cmd_data, cmd_ss, cmd_last,
      output rsp_ready, fault_clr,
      input  cmd_ready, rsp_valid, rsp_data, fault
   );

   modport slave (
      input  cfg_en, cfg_cpol, cfg_cpha, cfg_div,
      input  cmd_valid, cmd_data, cmd_ss, cmd_last,
      input  rsp_ready, fault_clr,
      output cmd_ready, rsp_valid, rsp_data, fault
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master engine: one word per command, four CPOL/CPHA modes, runtime
// divider, select held across bursts, sticky multi-master mode fault.
module spi_master_ctrl #(
   parameter int DATA_W    = 8,
   parameter int NUM_SS    = 3,
   parameter int DIV_W     = 8,
   parameter int LSB_FIRST = 0
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   spi_master_ctrl_if.slave  bus,
   input  logic              SCLKI,
   output logic              SCLKO,
   output logic              SCLKTN,
   input  logic              SI,
   output logic              MO,
   output logic              MOTN,
   input  logic              MI,
   output logic              SO,
   output logic              STN,
   input  logic              SSIN,
   output logic [NUM_SS-1:0] SSON,
   output logic              SSNTN
);

   localparam int CNT_W  = DIV_W + 1;
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
   localparam logic [EDGE_W-1:0] EDGE_PEN  = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_GAP, S_WAIT} state_t;

   state_t              r_state, w_state_next;
   logic [CNT_W-1:0]    r_cnt, w_cnt_next;
   logic [EDGE_W-1:0]   r_edge, w_edge_next;
   logic                r_cpol, w_cpol_next;
   logic                r_cpha, w_cpha_next;
   logic [DIV_W-1:0]    r_div, w_div_next;
   logic [DATA_W-1:0]   r_tx, w_tx_next;
   logic [DATA_W-1:0]   r_rx, w_rx_next;
   logic                r_last, w_last_next;
   logic                r_sclk, w_sclk_next;
   logic                r_mo, w_mo_next;
   logic [NUM_SS-1:0]   r_sson, w_sson_next;
   logic                r_rsp_valid, w_rsp_valid_next;
   logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_next;
   logic                r_fault, w_fault_next;
   logic                r_oe_n, w_oe_n_next;
   logic                r_ssin_meta, r_ssin_sync;
   logic                r_rst_done;

   logic                w_cmd_ready, w_accept, w_trig, w_abort;
   logic                w_toggle, w_sample, w_update;
   logic [CNT_W-1:0]    w_div_ext, w_cfg_div_ext;
   logic                w_unused;

   // First bit to shift out of a word
   function automatic logic f_head(input logic [DATA_W-1:0] v);
      return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
   endfunction

   // Word after its head bit has been sent
   function automatic logic [DATA_W-1:0] f_shift_out(input logic [DATA_W-1:0] v);
      return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
   endfunction

   // Receive shift; after DATA_W samples the word is in natural bit order
   function automatic logic [DATA_W-1:0] f_shift_in(input logic [DATA_W-1:0] v, input logic b);
      return (LSB_FIRST != 0) ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
   endfunction

   assign w_unused      = ^{SCLKI, SI};
   assign w_div_ext     = {1'b0, r_div};
   assign w_cfg_div_ext = {1'b0, bus.cfg_div};
   assign w_cmd_ready   = r_rst_done & ((r_state == S_IDLE) | (r_state == S_WAIT)) &
                          ~r_rsp_valid & ~r_fault & bus.cfg_en;
   assign w_accept      = bus.cmd_valid & w_cmd_ready;
   assign w_trig        = ~r_ssin_sync & bus.cfg_en & ((r_state != S_IDLE) | bus.cmd_valid);
   assign w_abort       = w_trig | ~bus.cfg_en;
   // Even toggle index = leading edge; CPHA picks which edge samples
   assign w_sample      = r_cpha ? r_edge[0] : ~r_edge[0];
   assign w_update      = ~w_sample & ~(~r_cpha & (r_edge == EDGE_PEN));

   // Next-state, datapath and pin values for the transfer sequencer
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_edge_next      = r_edge;
      w_cpol_next      = r_cpol;
      w_cpha_next      = r_cpha;
      w_div_next       = r_div;
      w_tx_next        = r_tx;
      w_rx_next        = r_rx;
      w_last_next      = r_last;
      w_sclk_next      = r_sclk;
      w_mo_next        = r_mo;
      w_sson_next      = r_sson;
      w_rsp_valid_next = r_rsp_valid;
      w_rsp_data_next  = r_rsp_data;
      w_toggle         = 1'b0;

      if (r_rsp_valid && bus.rsp_ready) begin
         w_rsp_valid_next = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            w_sclk_next = bus.cfg_cpol;
            w_sson_next = '1;
            if (w_accept) begin
               w_cpol_next  = bus.cfg_cpol;
               w_cpha_next  = bus.cfg_cpha;
               w_div_next   = bus.cfg_div;
               w_last_next  = bus.cmd_last;
               w_sson_next  = ~bus.cmd_ss;
               // one extra lead cycle lets the select settle before the first edge
               w_cnt_next   = w_cfg_div_ext + CNT_ONE;
               w_edge_next  = '0;
               w_rx_next    = '0;
               w_state_next = S_LEAD;
               if (!bus.cfg_cpha) begin
                  w_mo_next = f_head(bus.cmd_data);
                  w_tx_next = f_shift_out(bus.cmd_data);
               end else begin
                  w_tx_next = bus.cmd_data;
               end
            end
         end
         S_LEAD: begin
            if (r_cnt == '0) begin
               w_state_next = S_XFER;
               w_cnt_next   = w_div_ext;
               w_toggle     = 1'b1;
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
            end
         end
         S_XFER: begin
            if (r_cnt == '0) begin
               w_cnt_next = w_div_ext;
               if (r_edge == EDGE_LAST) begin
                  w_state_next = S_TRAIL;
               end else begin
                  w_toggle = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
            end
         end
         S_TRAIL: begin
            w_sclk_next = r_cpol;
            if (r_cnt == '0) begin
               w_rsp_valid_next = 1'b1;
               w_rsp_data_next  = r_rx;
               w_cnt_next       = w_div_ext;
               if (r_last) begin
                  w_state_next = S_GAP;
                  w_sson_next  = '1;
               end else begin
                  w_state_next = S_WAIT;
               end
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
            end
         end
         S_GAP: begin
            w_sson_next = '1;
            if (r_cnt == '0) begin
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt - CNT_ONE;
            end
         end
         S_WAIT: begin
            w_sclk_next = r_cpol;
            // select and clock configuration carry over from the first word
            if (w_accept) begin
               w_last_next  = bus.cmd_last;
               w_cnt_next   = w_div_ext + CNT_ONE;
               w_edge_next  = '0;
               w_rx_next    = '0;
               w_state_next = S_LEAD;
               if (!r_cpha) begin
                  w_mo_next = f_head(bus.cmd_data);
                  w_tx_next = f_shift_out(bus.cmd_data);
               end else begin
                  w_tx_next = bus.cmd_data;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      if (w_toggle) begin
         w_sclk_next = ~r_sclk;
         w_edge_next = r_edge + EDGE_ONE;
         if (w_sample) begin
            w_rx_next = f_shift_in(r_rx, MI);
         end else if (w_update) begin
            w_mo_next = f_head(r_tx);
            w_tx_next = f_shift_out(r_tx);
         end
      end

      // Abort drops the word in flight; an older pending response survives
      if (w_abort) begin
         w_state_next     = S_IDLE;
         w_sson_next      = '1;
         w_sclk_next      = bus.cfg_cpol;
         w_rsp_valid_next = r_rsp_valid & ~bus.rsp_ready;
         w_rsp_data_next  = r_rsp_data;
      end
   end

   // Fault is sticky; a fresh trigger beats a clear in the same cycle
   always_comb begin
      w_fault_next = r_fault;
      if (w_trig) begin
         w_fault_next = 1'b1;
      end else if (bus.fault_clr) begin
         w_fault_next = 1'b0;
      end
      w_oe_n_next = ~(bus.cfg_en & ~w_fault_next);
   end

   // State and datapath registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_edge      <= '0;
         r_cpol      <= 1'b0;
         r_cpha      <= 1'b0;
         r_div       <= '0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_last      <= 1'b0;
         r_sclk      <= 1'b0;
         r_mo        <= 1'b0;
         r_sson      <= '1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_fault     <= 1'b0;
         r_oe_n      <= 1'b1;
         r_rst_done  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_edge      <= w_edge_next;
         r_cpol      <= w_cpol_next;
         r_cpha      <= w_cpha_next;
         r_div       <= w_div_next;
         r_tx        <= w_tx_next;
         r_rx        <= w_rx_next;
         r_last      <= w_last_next;
         r_sclk      <= w_sclk_next;
         r_mo        <= w_mo_next;
         r_sson      <= w_sson_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_rsp_data  <= w_rsp_data_next;
         r_fault     <= w_fault_next;
         r_oe_n      <= w_oe_n_next;
         r_rst_done  <= 1'b1;
      end
   end

   // Two-flop synchroniser for the external select; idles inactive (high)
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_ssin_meta <= 1'b1;
         r_ssin_sync <= 1'b1;
      end else begin
         r_ssin_meta <= SSIN;
         r_ssin_sync <= r_ssin_meta;
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.fault     = r_fault;
   assign SCLKO         = r_sclk;
   assign MO            = r_mo;
   assign SSON          = r_sson;
   assign SCLKTN        = r_oe_n;
   assign MOTN          = r_oe_n;
   assign SSNTN         = r_oe_n;
   assign SO            = 1'b0;
   assign STN           = 1'b1;

endmodule
